// File: rtl/gnrl_dffl.sv
// gnrl_dffl: load-enable flop without reset, used for FIFO storage entries
module gnrl_dffl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk) begin
        if (lden) qout <= dnxt;
    end
endmodule

// File: rtl/gnrl_dfflrs.sv
// gnrl_dfflrs: load-enable flop with synchronous active-low reset to zero
module gnrl_dfflrs #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk) begin
        if (!rst_n) qout <= '0;
        else if (lden) qout <= dnxt;
    end
endmodule

// File: rtl/gnrl_pipe_fifo.sv
// gnrl_pipe_fifo: registered-output FIFO with optional ready cut and synchronous flush
module gnrl_pipe_fifo #(
    parameter int DW        = 32,
    parameter int DP        = 2,
    parameter int CUT_READY = 0,
    localparam int CW       = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] count
);
    localparam int PW = DP > 1 ? $clog2(DP) : 1;
    logic [PW-1:0] rptr, wptr, rptr_nxt, wptr_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [DW-1:0] mem [DP];
    logic [DW-1:0] head;
    logic          push, pop;
    assign o_vld    = count != '0;
    assign i_rdy    = (count != CW'(DP)) | (CUT_READY != 0 ? 1'b0 : o_rdy);
    assign push     = i_vld & i_rdy & ~flush;
    assign pop      = o_vld & o_rdy & ~flush;
    assign wptr_nxt = (flush || wptr == PW'(DP - 1)) ? '0 : wptr + 1'b1;
    assign rptr_nxt = (flush || rptr == PW'(DP - 1)) ? '0 : rptr + 1'b1;
    // count only loads when it actually changes, so push alone means +1
    assign cnt_nxt  = flush ? '0 : push ? count + 1'b1 : count - 1'b1;
    gnrl_dfflrs #(.DW(PW)) u_wptr (
        .clk(clk), .rst_n(rst_n), .lden(flush | push), .dnxt(wptr_nxt), .qout(wptr)
    );
    gnrl_dfflrs #(.DW(PW)) u_rptr (
        .clk(clk), .rst_n(rst_n), .lden(flush | pop), .dnxt(rptr_nxt), .qout(rptr)
    );
    gnrl_dfflrs #(.DW(CW)) u_cnt (
        .clk(clk), .rst_n(rst_n), .lden(flush | (push ^ pop)), .dnxt(cnt_nxt), .qout(count)
    );
    for (genvar e = 0; e < DP; e++) begin : g_ent
        gnrl_dffl #(.DW(DW)) u_ent (
            .clk(clk), .lden(push && wptr == PW'(e)), .dnxt(i_dat), .qout(mem[e])
        );
    end
    always_comb begin
        head = '0;
        for (int k = 0; k < DP; k++) head = (rptr == PW'(k)) ? mem[k] : head;
    end
    assign o_dat = o_vld ? head : '0;
endmodule

// File: doc/gnrl_pipe_fifo.md
GNRL_PIPE_FIFO -- requirements
Module: gnrl_pipe_fifo

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits, at least 1.
REQ-002 SHALL have parameter DP, default 2: entry depth, at least 1; non-power-of-two values are legal.
REQ-003 SHALL have parameter CUT_READY, default 0:
- 1: i_rdy depends on registered state only.
- 0: i_rdy also passes o_rdy through.
REQ-004 SHALL define localparam CW = $clog2(DP+1): width of the occupancy count.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset; synchronous, active-low.
- flush, input, 1: synchronous discard of all entries.
- i_vld, input, 1: write-side valid.
- i_rdy, output, 1: write-side ready.
- i_dat, input, DW: write data.
- o_vld, output, 1: read-side valid.
- o_rdy, input, 1: read-side ready.
- o_dat, output, DW: read data (head entry).
- count, output, CW: current number of stored entries.

Function
REQ-006 SHALL define push = i_vld & i_rdy & ~flush and pop = o_vld & o_rdy & ~flush.
REQ-007 SHALL drive o_vld = (count != 0) and o_dat = head entry when o_vld=1, else all zeros.
REQ-008 SHALL, with CUT_READY=1, drive i_rdy = (count != DP).
REQ-009 SHALL, with CUT_READY=0, drive i_rdy = (count != DP) | o_rdy, so a full FIFO accepts a push in the same cycle as a pop.
REQ-010 SHALL write i_dat into the entry at the write pointer on push; the data is visible on o_dat no earlier than the next cycle (latency 1, no i_dat to o_dat combinational path).
REQ-011 SHALL advance the read pointer on pop; the next entry is presented on o_dat in the following cycle.
REQ-012 SHALL wrap each pointer from DP-1 to 0; no other wrap point is permitted.
REQ-013 SHALL update count as follows:
- push only: +1.
- pop only: -1.
- push and pop together: unchanged.
- count never exceeds DP and never goes below 0.
REQ-014 SHALL, when empty and i_vld=1, accept the push; o_vld rises next cycle. There is no fall-through.
REQ-015 SHALL, on flush=1, set count and both pointers to 0 at the next edge and ignore push/pop in that cycle; storage contents are not cleared.
REQ-016 SHALL hold o_dat and o_vld stable while o_vld=1 and o_rdy=0, unless flush or reset occurs.
REQ-017 SHALL, with DP=1, behave as a single-entry pipe register with identical handshake rules.

Reset
REQ-018 SHALL, when rst_n=0 at a rising edge, set count=0, read pointer=0 and write pointer=0; rst_n has priority over flush, push and pop.
REQ-019 SHALL present the following outputs after reset: o_vld=0, o_dat=0, count=0, i_rdy=1.
REQ-020 SHALL not reset the storage array; an entry may be read only after it has been written.
REQ-021 SHALL drop any in-flight push or pop when reset is asserted mid-operation; no entry survives reset.

Structure
REQ-022 SHALL need no shared package; CW and pointer widths are local parameters.
REQ-023 SHALL build control registers (pointers, count) from one new sub-module, gnrl_dfflrs: parametrised DW, load enable, synchronous active-low reset to 0.
REQ-024 SHALL build storage from the existing load-enable, no-reset flop (gnrl_dffl), one instance per entry.

Verification
REQ-025 SHALL cover fill/drain: DW=8, DP=4, CUT_READY=1; push 0x11, 0x22, 0x33, 0x44 with o_rdy=0 -> count=4, i_rdy=0; then o_rdy=1 -> o_dat sequence 0x11, 0x22, 0x33, 0x44, count=0, o_vld=0.
REQ-026 SHALL cover full with simultaneous push/pop: DP=4, CUT_READY=0, FIFO full, i_vld=1, o_rdy=1 -> i_rdy=1, count stays 4, order preserved. Repeat with CUT_READY=1 -> i_rdy=0, count drops to 3.
REQ-027 SHALL cover wrap-around: DP=3; run 10 push/pop pairs with data 0..9 -> output order 0..9, count never exceeds 3.
REQ-028 SHALL cover flush: count=2; assert flush together with i_vld=1 and o_rdy=1 -> next cycle count=0, o_vld=0, o_dat=0; the pushed word never appears on o_dat.
REQ-029 SHALL cover reset mid-stream: count=3; drive rst_n=0 for one edge -> count=0, o_vld=0, i_rdy=1. Then push 0xA5 -> o_dat=0xA5 one cycle later.
REQ-030 SHALL cover backpressure: DP=1, CUT_READY=0, o_rdy toggling 1/0 every cycle, i_vld held at 1 -> o_dat stable whenever o_rdy=0 and no data is lost or duplicated.
